// File: rtl/wb_gpio_pkg.sv
// Shared definitions for the Wishbone GPIO bank: register map, address field
// positions and the byte-lane mask helper.
package wb_gpio_pkg;

    typedef enum logic [2:0] {
        REG_OUT  = 3'd0,
        REG_SET  = 3'd1,
        REG_CLR  = 3'd2,
        REG_TGL  = 3'd3,
        REG_IN   = 3'd4,
        REG_EDGE = 3'd5,
        REG_IEN  = 3'd6,
        REG_RSVD = 3'd7
    } reg_idx_e;

    localparam int REG_IDX_LSB  = 2;
    localparam int CH_IDX_LSB   = 5;
    localparam int MAX_CHANNELS = 8;

    // Expands the 4 byte-lane enables into a 32-bit bit mask; callers keep
    // only the low WIDTH bits, which drops lanes beyond the channel width.
    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) begin
            m[b*8 +: 8] = {8{sel[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Per-channel input synchroniser with rising-edge detection. The edge output
// is combinational from the last sync stage and the previous-sample register
// so the parent can register it into its status bits at the next edge.
module gpio_sync_edge #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;

    // Shift the asynchronous inputs through the synchroniser chain and keep
    // the previous synchronised sample for edge comparison.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                stage_q[s] <= '0;
            end
            prev_q <= '0;
        end else begin
            stage_q[0] <= in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                stage_q[s] <= stage_q[s-1];
            end
            prev_q <= stage_q[SYNC_STAGES-1];
        end
    end

    assign sync_out = stage_q[SYNC_STAGES-1];
    assign rise     = enable ? (sync_out & ~prev_q) : '0;

endmodule

// File: rtl/wb_gpio_bank.sv
// Multi-channel Wishbone GPIO slave: per-channel output register with
// byte-lane writes and set/clear/toggle aliases, synchronised input readback,
// rising-edge capture with interrupt enables and a combined interrupt.
//
// Bus handshake: a request is taken at a rising edge when cyc_i & stb_i are
// high and no termination is currently being presented (!ack_o & !err_o).
// At that edge exactly one of ack_o/err_o rises for one cycle, any write is
// committed and dat_o is loaded; dat_o is 0 whenever no termination is shown.
// A master holding stb_i therefore gets at most one access every 2 cycles.
module wb_gpio_bank
    import wb_gpio_pkg::*;
#(
    parameter int          WIDTH       = 32,
    parameter int          CHANNELS    = 4,
    parameter logic [31:0] RESET_PAT   = 32'h0000_0000,
    parameter int          ADDR_WIDTH  = 32,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [ADDR_WIDTH-1:0]     adr_i,
    input  logic [31:0]               dat_i,
    output logic [31:0]               dat_o,
    input  logic [3:0]                sel_i,
    input  logic                      we_i,
    input  logic                      stb_i,
    input  logic                      cyc_i,
    output logic                      ack_o,
    output logic                      err_o,
    output logic [CHANNELS*WIDTH-1:0] gpio_out,
    input  logic [CHANNELS*WIDTH-1:0] gpio_in,
    output logic                      irq
);

    localparam int          GW        = CHANNELS * WIDTH;
    localparam int          MASK_CYC  = SYNC_STAGES + 1;
    localparam int          CW        = $clog2(MASK_CYC + 1);
    localparam logic [3:0]  NUM_CH    = 4'(CHANNELS);

    logic [GW-1:0]    out_q, out_n;
    logic [GW-1:0]    edge_q, edge_n;
    logic [GW-1:0]    ien_q, ien_n;
    logic [GW-1:0]    sync_all;
    logic [GW-1:0]    rise_all;
    logic [CW-1:0]    mask_cnt;
    logic             edge_en;

    logic [2:0]       ch_idx;
    reg_idx_e         reg_idx;
    logic             req;
    logic             bad_addr;
    logic             wr_ok;
    logic [31:0]      lane_bits;
    logic [WIDTH-1:0] wmask;
    logic [WIDTH-1:0] wbits;
    logic [31:0]      rd_data;
    logic             unused_bits;

    assign ch_idx    = adr_i[CH_IDX_LSB +: 3];
    assign reg_idx   = reg_idx_e'(adr_i[REG_IDX_LSB +: 3]);
    assign req       = cyc_i & stb_i & ~ack_o & ~err_o;
    assign bad_addr  = ({1'b0, ch_idx} >= NUM_CH) || (reg_idx == REG_RSVD);
    assign wr_ok     = req & we_i & ~bad_addr;
    assign lane_bits = lane_mask(sel_i);
    assign wmask     = lane_bits[WIDTH-1:0];
    assign wbits     = dat_i[WIDTH-1:0] & wmask;

    // Address bits above the channel field and unused data/lane bits.
    assign unused_bits = ^{adr_i, dat_i, lane_bits};

    // Hold off edge capture until the synchronisers carry post-reset samples,
    // so inputs already high at reset release are not seen as edges.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mask_cnt <= '0;
        end else if (mask_cnt != CW'(MASK_CYC)) begin
            mask_cnt <= mask_cnt + 1'b1;
        end
    end

    assign edge_en = (mask_cnt == CW'(MASK_CYC));

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        gpio_sync_edge #(
            .WIDTH       (WIDTH),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync_edge (
            .clock    (clock),
            .reset    (reset),
            .enable   (edge_en),
            .in       (gpio_in[c*WIDTH +: WIDTH]),
            .sync_out (sync_all[c*WIDTH +: WIDTH]),
            .rise     (rise_all[c*WIDTH +: WIDTH])
        );
    end

    // Next-state for output, edge-status and enable registers; a new edge
    // overrides a same-cycle write-1-to-clear on the same bit.
    always_comb begin
        out_n  = out_q;
        edge_n = edge_q | rise_all;
        ien_n  = ien_q;
        for (int c = 0; c < CHANNELS; c++) begin
            if (wr_ok && (ch_idx == 3'(c))) begin
                case (reg_idx)
                    REG_OUT:  out_n[c*WIDTH +: WIDTH] = (out_q[c*WIDTH +: WIDTH] & ~wmask) | wbits;
                    REG_SET:  out_n[c*WIDTH +: WIDTH] = out_q[c*WIDTH +: WIDTH] | wbits;
                    REG_CLR:  out_n[c*WIDTH +: WIDTH] = out_q[c*WIDTH +: WIDTH] & ~wbits;
                    REG_TGL:  out_n[c*WIDTH +: WIDTH] = out_q[c*WIDTH +: WIDTH] ^ wbits;
                    REG_EDGE: edge_n[c*WIDTH +: WIDTH] = (edge_q[c*WIDTH +: WIDTH] & ~wbits)
                                                         | rise_all[c*WIDTH +: WIDTH];
                    REG_IEN:  ien_n[c*WIDTH +: WIDTH] = (ien_q[c*WIDTH +: WIDTH] & ~wmask) | wbits;
                    default:  ;
                endcase
            end
        end
    end

    // Read multiplexer; SET/CLR/TGL alias the output register on reads.
    always_comb begin
        rd_data = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (ch_idx == 3'(c)) begin
                case (reg_idx)
                    REG_OUT, REG_SET, REG_CLR, REG_TGL:
                              rd_data = 32'(out_q[c*WIDTH +: WIDTH]);
                    REG_IN:   rd_data = 32'(sync_all[c*WIDTH +: WIDTH]);
                    REG_EDGE: rd_data = 32'(edge_q[c*WIDTH +: WIDTH]);
                    REG_IEN:  rd_data = 32'(ien_q[c*WIDTH +: WIDTH]);
                    default:  rd_data = '0;
                endcase
            end
        end
    end

    // Register state, bus terminations, read data and the interrupt.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_q  <= {CHANNELS{RESET_PAT[WIDTH-1:0]}};
            edge_q <= '0;
            ien_q  <= '0;
            ack_o  <= 1'b0;
            err_o  <= 1'b0;
            dat_o  <= '0;
            irq    <= 1'b0;
        end else begin
            out_q  <= out_n;
            edge_q <= edge_n;
            ien_q  <= ien_n;
            ack_o  <= req & ~bad_addr;
            err_o  <= req & bad_addr;
            dat_o  <= (req & ~bad_addr) ? rd_data : '0;
            irq    <= |(edge_q & ien_q);
        end
    end

    assign gpio_out = out_q;

endmodule

// File: tb/tb_wb_gpio_bank.sv
// Directed bench for wb_gpio_bank: bus stimulus pushes expected terminations
// into a queue that a negedge monitor pops and compares.
module tb_wb_gpio_bank;

    localparam int          WIDTH       = 32;
    localparam int          CHANNELS    = 4;
    localparam int          SYNC_STAGES = 2;
    localparam logic [31:0] RESET_PAT   = 32'h1133_5577;
    localparam int          GW          = CHANNELS * WIDTH;

    localparam logic [2:0] R_OUT = 3'd0, R_SET = 3'd1, R_CLR = 3'd2, R_TGL = 3'd3,
                           R_IN = 3'd4, R_EDGE = 3'd5, R_IEN = 3'd6, R_RSVD = 3'd7;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   adr_i = '0;
    logic [31:0]   dat_i = '0;
    logic [31:0]   dat_o;
    logic [3:0]    sel_i = '0;
    logic          we_i  = 1'b0;
    logic          stb_i = 1'b0;
    logic          cyc_i = 1'b0;
    logic          ack_o;
    logic          err_o;
    logic [GW-1:0] gpio_out;
    logic [GW-1:0] gpio_in = '0;
    logic          irq;

    // Expected termination: {err, check_data, data}
    logic [33:0]   exp_q[$];
    int            total = 0;
    int            bad   = 0;

    // Clock and DUT
    always #5 clock = ~clock;

    wb_gpio_bank #(
        .WIDTH       (WIDTH),
        .CHANNELS    (CHANNELS),
        .RESET_PAT   (RESET_PAT),
        .ADDR_WIDTH  (32),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .adr_i    (adr_i),
        .dat_i    (dat_i),
        .dat_o    (dat_o),
        .sel_i    (sel_i),
        .we_i     (we_i),
        .stb_i    (stb_i),
        .cyc_i    (cyc_i),
        .ack_o    (ack_o),
        .err_o    (err_o),
        .gpio_out (gpio_out),
        .gpio_in  (gpio_in),
        .irq      (irq)
    );

    task automatic check(input string name, input logic [GW-1:0] act, input logic [GW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every termination pops one expectation
    always @(negedge clock) begin
        logic [33:0] e;
        if (!reset && (ack_o || err_o)) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_term: ack=%0b err=%0b dat=%h", ack_o, err_o, dat_o);
            end else begin
                e = exp_q.pop_front();
                if ({err_o, ack_o} !== {e[33], ~e[33]} || (e[32] && dat_o !== e[31:0])) begin
                    bad++;
                    $display("FAIL bus_term: got ack=%0b err=%0b dat=%h want err=%0b dat=%h",
                             ack_o, err_o, dat_o, e[33], e[31:0]);
                end
            end
        end
    end

    // Driver: one access, returns #1 after the terminating edge
    task automatic bus_access(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                              input logic [31:0] dat, input logic exp_err,
                              input logic chk, input logic [31:0] exp_dat);
        int lat;
        exp_q.push_back({exp_err, chk, exp_dat});
        @(posedge clock); #1;
        adr_i = adr; we_i = we; sel_i = sel; dat_i = dat;
        cyc_i = 1'b1; stb_i = 1'b1;
        lat = 0;
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            @(posedge clock); #1;
            if (ack_o || err_o) lat = i;
        end
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        if (lat == 0) begin
            total++; bad++;
            $display("FAIL bus_timeout: adr=%h no termination within 8 cycles", adr);
            void'(exp_q.pop_back());
        end else begin
            check("latency", GW'(lat), GW'(1));
        end
    endtask

    function automatic logic [31:0] addr(input int ch, input logic [2:0] r);
        return 32'((ch << 5) | (int'(r) << 2));
    endfunction

    task automatic wr(input int ch, input logic [2:0] r, input logic [31:0] d, input logic [3:0] sel);
        bus_access(addr(ch, r), 1'b1, sel, d, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic rd(input int ch, input logic [2:0] r, input logic [31:0] exp);
        bus_access(addr(ch, r), 1'b0, 4'hF, 32'h0, 1'b0, 1'b1, exp);
    endtask

    // Directed sequence
    initial begin
        logic [5:0] ack_pat;

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Reset state
        check("rst_gpio_out", gpio_out, {CHANNELS{RESET_PAT}});
        check("rst_ack", GW'(ack_o), GW'(0));
        check("rst_err", GW'(err_o), GW'(0));
        check("rst_irq", GW'(irq), GW'(0));
        check("rst_dat_o", GW'(dat_o), GW'(0));
        rd(0, R_OUT, 32'h1133_5577);

        // Byte lanes and set/clear/toggle aliases on channel 1
        wr(1, R_OUT, 32'h0000_0000, 4'hF);
        check("ch1_zero", GW'(gpio_out[63:32]), GW'(32'h0));
        wr(1, R_OUT, 32'hDEAD_BEEF, 4'b0101);
        check("ch1_lanes", GW'(gpio_out[63:32]), GW'(32'h00AD_00EF));
        wr(1, R_SET, 32'hF000_0000, 4'hF);
        check("ch1_set", GW'(gpio_out[63:32]), GW'(32'hF0AD_00EF));
        wr(1, R_CLR, 32'h0000_00FF, 4'hF);
        check("ch1_clr", GW'(gpio_out[63:32]), GW'(32'hF0AD_0000));
        wr(1, R_TGL, 32'h0000_0001, 4'hF);
        check("ch1_tgl", GW'(gpio_out[63:32]), GW'(32'hF0AD_0001));
        wr(1, R_OUT, 32'h0000_0000, 4'h0);
        check("ch1_sel0", GW'(gpio_out[63:32]), GW'(32'hF0AD_0001));
        wr(1, R_IN, 32'hFFFF_FFFF, 4'hF);
        rd(1, R_SET, 32'hF0AD_0001);
        rd(1, R_TGL, 32'hF0AD_0001);

        // Error terminations change nothing
        bus_access(32'h0000_0080, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0);
        check("err_ch4_nochange", gpio_out,
              {RESET_PAT, RESET_PAT, 32'hF0AD_0001, RESET_PAT});
        bus_access(32'h0000_001C, 1'b0, 4'hF, 32'h0, 1'b1, 1'b1, 32'h0);
        bus_access(addr(1, R_RSVD), 1'b1, 4'hF, 32'h0, 1'b1, 1'b1, 32'h0);
        check("err_rsvd_nochange", gpio_out,
              {RESET_PAT, RESET_PAT, 32'hF0AD_0001, RESET_PAT});

        // Edge capture and interrupt on channel 2 bit 3
        wr(2, R_IEN, 32'h0000_0008, 4'hF);
        rd(2, R_IEN, 32'h0000_0008);
        gpio_in[2*WIDTH+3] = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("irq_not_early", GW'(irq), GW'(0));
        @(posedge clock); #1;
        check("irq_rise", GW'(irq), GW'(1));
        rd(2, R_EDGE, 32'h0000_0008);
        rd(2, R_IN, 32'h0000_0008);
        wr(2, R_EDGE, 32'h0000_0008, 4'hF);
        check("irq_lag_after_w1c", GW'(irq), GW'(1));
        @(posedge clock); #1;
        check("irq_fall", GW'(irq), GW'(0));
        rd(2, R_EDGE, 32'h0000_0000);

        // Same-cycle W1C and new edge: set wins
        gpio_in[2*WIDTH+3] = 1'b0;
        repeat (4) @(posedge clock);
        #1 gpio_in[2*WIDTH+3] = 1'b1;
        @(posedge clock);
        wr(2, R_EDGE, 32'h0000_0008, 4'hF);
        rd(2, R_EDGE, 32'h0000_0008);

        // Strobe held: one access every 2 cycles
        for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, 1'b1, RESET_PAT});
        @(posedge clock); #1;
        adr_i = addr(0, R_OUT); we_i = 1'b0; sel_i = 4'hF;
        cyc_i = 1'b1; stb_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            ack_pat[5-i] = ack_o;
        end
        cyc_i = 1'b0; stb_i = 1'b0;
        check("ack_toggle", GW'(ack_pat), GW'(6'b101010));

        // Reset mid-access with all inputs high through release
        @(posedge clock); #1;
        gpio_in = '1;
        adr_i = addr(1, R_OUT); we_i = 1'b1; sel_i = 4'hF; dat_i = 32'hFFFF_FFFF;
        cyc_i = 1'b1; stb_i = 1'b1;
        #2 reset = 1'b1;
        @(posedge clock); #1;
        check("midrst_no_ack", GW'(ack_o), GW'(0));
        check("midrst_gpio_out", gpio_out, {CHANNELS{RESET_PAT}});
        check("midrst_irq", GW'(irq), GW'(0));
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        @(posedge clock); #1 reset = 1'b0;
        repeat (10) @(posedge clock);
        for (int c = 0; c < CHANNELS; c++) rd(c, R_EDGE, 32'h0000_0000);
        rd(2, R_IEN, 32'h0000_0000);
        rd(3, R_IN, 32'hFFFF_FFFF);
        check("post_irq", GW'(irq), GW'(0));

        repeat (3) @(posedge clock);
        check("queue_empty", GW'(exp_q.size()), GW'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/wb_gpio_bank.md
Name: wb_gpio_bank

Overview:
Parametrised multi-channel Wishbone GPIO slave. It succeeds the single fixed output register used for the board LEDs. It provides CHANNELS output registers with byte-lane writes and atomic set/clear/toggle aliases. It also provides synchronised input readback, rising-edge capture and a combined interrupt. It sits behind the data-bus interconnect as a slave, and drives the LEDs/segments and samples the switches/buttons.

Parameters:
WIDTH, 32, data width of each channel; multiple of 8, 8..32
CHANNELS, 4, number of channels; 1..8
RESET_PAT, 32'h0000_0000, reset value of every output channel; bits [WIDTH-1:0] are used
ADDR_WIDTH, 32, width of adr_i
SYNC_STAGES, 2, input synchroniser depth; minimum 2

Ports:
clock  in  1  system clock; all state is updated on its rising edge
reset  in  1  asynchronous, active-high reset
adr_i  in  ADDR_WIDTH  byte address; [4:2] selects the register, [7:5] selects the channel, higher bits are ignored
dat_i  in  32  write data
dat_o  out  32  read data; registered, valid while ack_o or err_o is high, 0 otherwise
sel_i  in  4  byte-lane enables
we_i  in  1  write enable
stb_i  in  1  strobe
cyc_i  in  1  bus cycle
ack_o  out  1  normal termination, 1-cycle pulse
err_o  out  1  error termination, 1-cycle pulse
gpio_out  out  CHANNELS*WIDTH  output registers; channel c occupies [c*WIDTH +: WIDTH]
gpio_in  in  CHANNELS*WIDTH  asynchronous inputs, same packing
irq  out  1  registered OR over channels of (EDGE & IEN)

Behaviour:
- Reset values: gpio_out=RESET_PAT[WIDTH-1:0] per channel; EDGE=0, IEN=0, synchronisers=0, ack_o=0, err_o=0, dat_o=0, irq=0.
- Request accepted when cyc_i & stb_i & !ack_o & !err_o at a rising edge.
- At the same edge, ack_o or err_o rises for exactly 1 cycle, the write is committed and dat_o is loaded. Latency is 1 cycle. Maximum rate is 1 access per 2 cycles.
- err_o is returned when channel >= CHANNELS or register index = 7. An erroring access changes no state.
- Register map per channel: 0 OUT (RW); 1 SET (W1S, reads OUT); 2 CLR (W1C, reads OUT); 3 TGL (write-1-toggles, reads OUT); 4 IN (RO, synchronised input; writes are acked and ignored); 5 EDGE (read status, W1C); 6 IEN (RW); 7 reserved.
- Byte lanes: lane b applies only if sel_i[b] and b*8 < WIDTH. sel_i=0 on a write gives an ack with no change.
- Read data bits [31:WIDTH] are 0.
- Input path: SYNC_STAGES flops, then a prev register. A rising edge (prev=0, sync=1) sets the corresponding EDGE bit.
- If a W1C to EDGE and a new edge hit the same bit in the same cycle, set wins.
- Edge detection is masked for SYNC_STAGES+1 cycles after reset release, using a saturating counter, so inputs already high at release do not create false edges.
- irq is registered, so it lags EDGE/IEN by 1 cycle.
- Reset asserted mid-access: all state returns to reset values immediately and no ack is issued. A request still pending after reset release is serviced normally.
- Output writes appear on gpio_out at the ack edge. There is no extra output pipeline.

Decomposition:
- Package wb_gpio_pkg:
  - Register-index enum: REG_OUT=0, REG_SET, REG_CLR, REG_TGL, REG_IN, REG_EDGE, REG_IEN, REG_RSVD=7.
  - REG_IDX_LSB=2, CH_IDX_LSB=5, MAX_CHANNELS=8.
  - Function applying sel_i as a WIDTH-bit byte mask.
- Sub-module gpio_sync_edge (parameters WIDTH, SYNC_STAGES):
  - Ports: clock, reset, enable, in, sync_out, rise.
  - One instance per channel, via generate.

Test Plan:
1. Reset with RESET_PAT=32'h11335577, WIDTH=32 -> gpio_out channel 0 = 32'h11335577. Read OUT ch0 -> ack 1 cycle after stb, dat_o=32'h11335577.
2. Write OUT ch1 = 32'hDEADBEEF with sel_i=4'b0101, prior value 0 -> ch1 = 32'h00AD00EF. Then SET 32'hF0000000 -> 32'hF0AD00EF. Then CLR 32'h000000FF -> 32'hF0AD0000. Then TGL 32'h00000001 -> 32'hF0AD0001.
3. Access adr_i=32'h0000_0080 (channel 4) with CHANNELS=4 -> err_o pulse, ack_o=0, no state change. adr_i=32'h1C (reg 7) -> err_o pulse.
4. gpio_in ch2 bit 3 goes 0->1; IEN ch2 = 32'h8 -> EDGE ch2 = 32'h8 SYNC_STAGES+1 cycles after the input change, irq 1 cycle later. W1C 32'h8 -> EDGE=0, irq falls the next cycle.
5. W1C to EDGE bit 3 in the same cycle a new rising edge on bit 3 is detected -> bit remains 1.
6. gpio_in all-ones held through reset release -> EDGE stays 0. stb held continuously -> ack_o toggles 1,0,1,0 (one access per 2 cycles). Reset asserted mid-access -> no ack, outputs return to RESET_PAT.
